// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants and FSM state types for the
// 640x480@60 Hz sync controller.
package vga_timing_pkg;

    localparam int unsigned CNT_W = 10;
    localparam int unsigned DIV_W = 4;

    localparam int unsigned DEF_DIV    = 2;
    localparam int unsigned DEF_H_VIS  = 640;
    localparam int unsigned DEF_H_FP   = 16;
    localparam int unsigned DEF_H_SYNC = 96;
    localparam int unsigned DEF_H_BP   = 48;
    localparam int unsigned DEF_V_VIS  = 480;
    localparam int unsigned DEF_V_FP   = 10;
    localparam int unsigned DEF_V_SYNC = 2;
    localparam int unsigned DEF_V_BP   = 33;

    localparam int unsigned H_TOTAL      = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned H_SYNC_START = DEF_H_VIS + DEF_H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + DEF_H_SYNC - 1;
    localparam int unsigned V_TOTAL      = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int unsigned V_SYNC_START = DEF_V_VIS + DEF_V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + DEF_V_SYNC - 1;

    typedef enum logic [1:0] {
        SEG_VIS,
        SEG_FP,
        SEG_SYNC,
        SEG_BP
    } seg_e;

    typedef enum logic [1:0] {
        H_VISIBLE,
        H_FRONT,
        H_SYNCP,
        H_BACK
    } h_state_e;

    typedef enum logic [1:0] {
        V_VISIBLE,
        V_FRONT,
        V_SYNCP,
        V_BACK
    } v_state_e;

endpackage

// File: rtl/contador_fase.sv
// Segment counter: counts 0..total-1 on each advance and tracks
// which of the four raster segments the count is in.
module contador_fase
    import vga_timing_pkg::*;
#(
    parameter int unsigned LEN_VIS  = DEF_H_VIS,
    parameter int unsigned LEN_FP   = DEF_H_FP,
    parameter int unsigned LEN_SYNC = DEF_H_SYNC,
    parameter int unsigned LEN_BP   = DEF_H_BP
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             adv_i,
    output logic [CNT_W-1:0] count_o,
    output seg_e             phase_d_o,
    output logic             wrap_o
);

    localparam logic [CNT_W-1:0] FP_AT   = CNT_W'(LEN_VIS);
    localparam logic [CNT_W-1:0] SYNC_AT = CNT_W'(LEN_VIS + LEN_FP);
    localparam logic [CNT_W-1:0] BP_AT   = CNT_W'(LEN_VIS + LEN_FP + LEN_SYNC);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(LEN_VIS + LEN_FP + LEN_SYNC + LEN_BP - 1);

    logic [CNT_W-1:0] count_q, count_d;
    seg_e             phase_q, phase_d;
    logic             wrap;

    // next count and segment; wrap is an explicit compare against the total
    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        wrap    = 1'b0;
        if (adv_i) begin
            if (count_q == LAST) begin
                count_d = '0;
                wrap    = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
            unique case (phase_q)
                SEG_VIS:  if (count_d == FP_AT)   phase_d = SEG_FP;
                SEG_FP:   if (count_d == SYNC_AT) phase_d = SEG_SYNC;
                SEG_SYNC: if (count_d == BP_AT)   phase_d = SEG_BP;
                SEG_BP:   if (wrap)               phase_d = SEG_VIS;
                default:  phase_d = SEG_VIS;
            endcase
        end
    end

    // count and segment state registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            phase_q <= SEG_VIS;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

    assign count_o   = count_q;
    assign phase_d_o = phase_d;
    assign wrap_o    = wrap;

endmodule

// File: rtl/controlador_sincronia.sv
// Raster sync controller: pixel-rate tick divider, horizontal and
// vertical segment counters, registered sync/visible decodes.
module controlador_sincronia
    import vga_timing_pkg::*;
#(
    parameter int unsigned DIV    = DEF_DIV,
    parameter int unsigned H_VIS  = DEF_H_VIS,
    parameter int unsigned H_FP   = DEF_H_FP,
    parameter int unsigned H_SYNC = DEF_H_SYNC,
    parameter int unsigned H_BP   = DEF_H_BP,
    parameter int unsigned V_VIS  = DEF_V_VIS,
    parameter int unsigned V_FP   = DEF_V_FP,
    parameter int unsigned V_SYNC = DEF_V_SYNC,
    parameter int unsigned V_BP   = DEF_V_BP
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             enable,
    output logic             pixel_tick,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             frame_start
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q;
    logic             hsync_q, vsync_q, video_on_q, frame_start_q;
    logic             adv, line_end, v_wrap;
    seg_e             h_phase_d, v_phase_d;
    h_state_e         h_nxt;
    v_state_e         v_nxt;

    // counters move only on a tick that the enable lets through
    assign adv = tick_q & enable;

    contador_fase #(
        .LEN_VIS  (H_VIS),
        .LEN_FP   (H_FP),
        .LEN_SYNC (H_SYNC),
        .LEN_BP   (H_BP)
    ) u_h (
        .clk_i     (Clk),
        .rst_i     (reset),
        .adv_i     (adv),
        .count_o   (pixel_x),
        .phase_d_o (h_phase_d),
        .wrap_o    (line_end)
    );

    contador_fase #(
        .LEN_VIS  (V_VIS),
        .LEN_FP   (V_FP),
        .LEN_SYNC (V_SYNC),
        .LEN_BP   (V_BP)
    ) u_v (
        .clk_i     (Clk),
        .rst_i     (reset),
        .adv_i     (line_end),
        .count_o   (pixel_y),
        .phase_d_o (v_phase_d),
        .wrap_o    (v_wrap)
    );

    assign h_nxt = h_state_e'(h_phase_d);
    assign v_nxt = v_state_e'(v_phase_d);

    // divider wraps at DIV-1; with DIV=1 it stays at 0
    always_comb begin
        div_d = div_q + DIV_W'(1);
        if (div_q == DIV_LAST) div_d = '0;
    end

    // divider and output registers; decodes use next-state counter phases
    always_ff @(posedge Clk) begin
        if (reset) begin
            div_q         <= '0;
            tick_q        <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (enable) begin
            div_q         <= div_d;
            tick_q        <= (div_q == DIV_LAST);
            hsync_q       <= (h_nxt != H_SYNCP);
            vsync_q       <= (v_nxt != V_SYNCP);
            video_on_q    <= (h_nxt == H_VISIBLE) && (v_nxt == V_VISIBLE);
            frame_start_q <= line_end & v_wrap;
        end
    end

    assign pixel_tick  = tick_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_controlador_sincronia.sv
// Directed bench for controlador_sincronia: default timing (DIV=2),
// DIV=1, and a shrunken raster for whole-frame checks.
module tb_controlador_sincronia;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, en_a, tka, hsa, vsa, vona, fsa;
    logic [9:0] xa, ya;
    logic       rst_b, en_b, tkb, hsb, vsb, vonb, fsb;
    logic [9:0] xb, yb;
    logic       rst_c, en_c, tkc, hsc, vsc, vonc, fsc;
    logic [9:0] xc, yc;

    int errs   = 0;
    int checks = 0;

    controlador_sincronia dut_a (
        .Clk(clk), .reset(rst_a), .enable(en_a), .pixel_tick(tka),
        .pixel_x(xa), .pixel_y(ya), .hsync(hsa), .vsync(vsa),
        .video_on(vona), .frame_start(fsa)
    );

    controlador_sincronia #(
        .DIV(2), .H_VIS(16), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_VIS(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) dut_b (
        .Clk(clk), .reset(rst_b), .enable(en_b), .pixel_tick(tkb),
        .pixel_x(xb), .pixel_y(yb), .hsync(hsb), .vsync(vsb),
        .video_on(vonb), .frame_start(fsb)
    );

    controlador_sincronia #(.DIV(1)) dut_c (
        .Clk(clk), .reset(rst_c), .enable(en_c), .pixel_tick(tkc),
        .pixel_x(xc), .pixel_y(yc), .hsync(hsc), .vsync(vsc),
        .video_on(vonc), .frame_start(fsc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // sel 0 = dut_a, 1 = dut_b; stops on the first (non-tick) cycle of a pixel
    task automatic wait_xy(input string tag, input int bud, input int sel,
                           input int wx, input int wy);
        bit hit = 1'b0;
        for (int i = 0; i < bud && !hit; i++) begin
            @(negedge clk);
            if (sel == 0) hit = (int'(xa) == wx) && (int'(ya) == wy) && !tka;
            else          hit = (int'(xb) == wx) && (int'(yb) == wy) && !tkb;
        end
        chk(tag, 32'(hit), 1);
    endtask

    int n_tk, n_hs, n_von, n_low, n_vs, bad, per, hs_x, nfs, fs0, fs1;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        en_a  = 1'b1; en_b  = 1'b1; en_c  = 1'b1;
        step(5);

        // reset state
        chk("a_rst_x", xa, 0);
        chk("a_rst_y", ya, 0);
        chk("a_rst_flags", {tka, hsa, vsa, vona, fsa}, 5'b01100);
        chk("c_rst_flags", {tkc, hsc, vsc, vonc, fsc}, 5'b01100);

        // release: first tick on the 2nd clock, pixel_x=1 after it
        rst_a = 1'b0;
        step(1);
        chk("a_rel1_tick", tka, 0);
        chk("a_rel1_von", vona, 1);
        step(1);
        chk("a_rel2_tick", tka, 1);
        chk("a_rel2_x", xa, 0);
        step(1);
        chk("a_rel3_x", xa, 1);
        chk("a_rel3_tick", tka, 0);

        // one full line (line 1) with per-cycle decode coherence
        wait_xy("a_wait_line1", 4000, 0, 0, 1);
        n_tk = 0; n_hs = 0; n_von = 0; bad = 0; per = 0; hs_x = -1;
        while (ya == 10'd1 && per < 2000) begin
            if (tka) begin
                n_tk++;
                if (!hsa) begin
                    n_hs++;
                    if (hs_x < 0) hs_x = int'(xa);
                end
                if (vona) n_von++;
            end
            if (hsa !== !(xa >= 10'd656 && xa <= 10'd751)) bad++;
            if (vona !== (xa < 10'd640)) bad++;
            if (vsa !== 1'b1) bad++;
            @(negedge clk);
            per++;
        end
        chk("a_line_period", per, 1600);
        chk("a_line_wrap_x", xa, 0);
        chk("a_line_wrap_y", ya, 2);
        chk("a_line_ticks", n_tk, 800);
        chk("a_hs_low_ticks", n_hs, 96);
        chk("a_hs_first_x", hs_x, 656);
        chk("a_von_ticks", n_von, 640);
        chk("a_decode_bad", bad, 0);

        // reset mid-line inside hsync
        wait_xy("a_wait_700", 4000, 0, 700, 2);
        chk("a_pre_rst_hs", hsa, 0);
        rst_a = 1'b1;
        step(1);
        chk("a_mid_rst_x", xa, 0);
        chk("a_mid_rst_y", ya, 0);
        chk("a_mid_rst_flags", {tka, hsa, vsa, vona, fsa}, 5'b01100);
        chk("a_mid_rst_div", dut_a.div_q, 0);
        rst_a = 1'b0;

        // enable dropped at pixel_x=100 with the divider at 1
        wait_xy("a_wait_100", 1000, 0, 100, 0);
        en_a = 1'b0;
        step(7);
        chk("a_frz_x", xa, 100);
        chk("a_frz_flags", {tka, hsa, vsa, vona, fsa}, 5'b01110);
        en_a = 1'b1;
        step(1);
        chk("a_reen_tick", tka, 1);
        chk("a_reen_x", xa, 100);
        step(1);
        chk("a_reen2_x", xa, 101);
        chk("a_reen2_tick", tka, 0);

        // DIV=1: tick always high, 800-clock lines
        rst_c = 1'b1;
        step(1);
        chk("c_rst_tick", tkc, 0);
        rst_c = 1'b0;
        step(1);
        chk("c_rel_tick", tkc, 1);
        chk("c_rel_x", xc, 0);
        n_low = 0; n_hs = 0; n_von = 0; bad = 0;
        for (int i = 0; i < 1600; i++) begin
            if (i == 799) chk("c_end_line0_x", xc, 799);
            if (i == 800) chk("c_line1_y", yc, 1);
            if (!tkc) n_low++;
            if (!hsc) n_hs++;
            if (vonc) n_von++;
            if (hsc !== !(xc >= 10'd656 && xc <= 10'd751)) bad++;
            if (xc != 10'(i % 800) || yc != 10'(i / 800)) bad++;
            step(1);
        end
        chk("c_tick_low", n_low, 0);
        chk("c_hs_low", n_hs, 192);
        chk("c_von", n_von, 1280);
        chk("c_bad", bad, 0);
        chk("c_end_xy", {xc, yc}, {10'd0, 10'd2});

        // shrunken raster: 32x12, DIV=2 -> 768-clock frames
        rst_b = 1'b0;
        step(2);
        chk("b_t0_tick", tkb, 1);
        chk("b_t0_xy", {xb, yb}, 20'd0);
        nfs = 0; fs0 = -1; fs1 = -1; n_vs = 0; bad = 0;
        for (int c = 0; c < 1541; c++) begin
            if (fsb) begin
                if (nfs == 0) fs0 = c;
                if (nfs == 1) fs1 = c;
                nfs++;
                if (xb != 10'd0 || yb != 10'd0) bad++;
            end
            if (!vsb && c < 767) n_vs++;
            if (vsb !== !(yb == 10'd8 || yb == 10'd9)) bad++;
            step(1);
        end
        chk("b_fs_count", nfs, 2);
        chk("b_fs_first", fs0, 767);
        chk("b_frame_period", fs1 - fs0, 768);
        chk("b_vs_low_clks", n_vs, 128);
        chk("b_bad", bad, 0);

        // reset inside vsync
        wait_xy("b_wait_vs", 2000, 1, 5, 9);
        chk("b_pre_rst_vs", vsb, 0);
        rst_b = 1'b1;
        step(1);
        chk("b_rst_flags", {tkb, hsb, vsb, vonb, fsb}, 5'b01100);
        chk("b_rst_xy", {xb, yb}, 20'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
